exec_stage_param: RTL

EXEC_STAGE_PARAM -- requirements
Module: exec_stage_param

---
 rtl/exec_stage_param_if.sv | 40 ++++
 rtl/exec_stage_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_param_if.sv
// Operand, control and result bundle between the decode/forwarding logic and exec_stage_param.
// The master side drives the instruction fields; the slave side returns the result, flags and stall.
interface exec_stage_param_if #(
   parameter int WORD_LENGTH = 8,
   parameter int SHIFT_WIDTH = 3
);
   logic [WORD_LENGTH-1:0] r1;
   logic [WORD_LENGTH-1:0] r2;
   logic [WORD_LENGTH-1:0] disp_const;
   logic                   aluBInputSel;
   logic [1:0]             aluInputAForwardingSel;
   logic [1:0]             aluInputBForwardingSel;
   logic [WORD_LENGTH-1:0] Ex_Mem_aluResult;
   logic [WORD_LENGTH-1:0] Mem_Wb_aluResult;
   logic [3:0]             ALUOperation;
   logic [SHIFT_WIDTH-1:0] shiftCount;
   logic                   opValid;
   logic                   ZEn;
   logic                   CEn;
   logic [WORD_LENGTH-1:0] ALUOUT;
   logic                   ZOutput;
   logic                   COutput;
   logic                   stall;

   modport master (
      output r1, r2, disp_const, aluBInputSel,
      output aluInputAForwardingSel, aluInputBForwardingSel,
      output Ex_Mem_aluResult, Mem_Wb_aluResult,
      output ALUOperation, shiftCount, opValid, ZEn, CEn,
      input  ALUOUT, ZOutput, COutput, stall
   );

   modport slave (
      input  r1, r2, disp_const, aluBInputSel,
      input  aluInputAForwardingSel, aluInputBForwardingSel,
      input  Ex_Mem_aluResult, Mem_Wb_aluResult,
      input  ALUOperation, shiftCount, opValid, ZEn, CEn,
      output ALUOUT, ZOutput, COutput, stall
   );
endinterface

// File: rtl/exec_stage_param.sv
// Execute stage: forwarding muxes, single-cycle ALU, Z/C flag registers and an optional
// iterative shift-and-add multiplier enabled by defining EXEC_STAGE_MUL_EN.
module exec_stage_param #(
   parameter int WORD_LENGTH = 8,
   parameter int SHIFT_WIDTH = 3
) (
   input logic               clk,
   input logic               rst,
   exec_stage_param_if.slave bus
);
   localparam int W = WORD_LENGTH;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADC = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_SBC = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_PSB = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_ROL = 4'b1010;
   localparam logic [3:0] OP_ROR = 4'b1011;
   localparam logic [3:0] OP_MUL = 4'b1100;

   logic [W-1:0] base_op [2];
   logic [W-1:0] fwd_op  [2];
   logic [1:0]   fwd_sel [2];
   logic [W-1:0] a_op;
   logic [W-1:0] b_op;

   logic         z_reg;
   logic         c_reg;
   logic [W-1:0] alu_result;
   logic         alu_carry;
   logic [W:0]   arith;
   logic [W:0]   shl_ext;
   logic [W:0]   shr_ext;
   logic         stall_int;
   logic [W-1:0] alu_out;

   assign base_op[0] = bus.r1;
   assign base_op[1] = bus.aluBInputSel ? bus.disp_const : bus.r2;
   assign fwd_sel[0] = bus.aluInputAForwardingSel;
   assign fwd_sel[1] = bus.aluInputBForwardingSel;

   // Select code 11 deliberately falls back to the base operand.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd_op[gi] = (fwd_sel[gi] == 2'b01) ? bus.Ex_Mem_aluResult :
                             (fwd_sel[gi] == 2'b10) ? bus.Mem_Wb_aluResult :
                                                      base_op[gi];
      end
   endgenerate

   assign a_op = fwd_op[0];
   assign b_op = fwd_op[1];

`ifdef EXEC_STAGE_MUL_EN
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]             state_reg, state_next;
   logic [SHIFT_WIDTH-1:0] count_reg, count_next;
   logic [2*W-1:0]         product_reg, product_next;
   logic [2*W-1:0]         mcand_reg, mcand_next;
   logic [W-1:0]           mplier_reg, mplier_next;
   logic                   mul_start;
   logic                   mul_done;

   assign mul_start = (state_reg == ST_IDLE) && bus.opValid && (bus.ALUOperation == OP_MUL);
   assign mul_done  = (state_reg == ST_DONE);
   assign stall_int = mul_start || (state_reg == ST_BUSY);

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      product_next = product_reg;
      mcand_next   = mcand_reg;
      mplier_next  = mplier_reg;
      case (state_reg)
         ST_IDLE: begin
            if (mul_start) begin
               mcand_next   = {{W{1'b0}}, a_op};
               mplier_next  = b_op;
               product_next = '0;
               count_next   = SHIFT_WIDTH'(W - 1);
               state_next   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (mplier_reg[0]) begin
               product_next = product_reg + mcand_reg;
            end
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            if (count_reg == '0) begin
               state_next = ST_DONE;
            end else begin
               count_next = count_reg - SHIFT_WIDTH'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         count_reg   <= '0;
         product_reg <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         product_reg <= product_next;
         mcand_reg   <= mcand_next;
         mplier_reg  <= mplier_next;
      end
   end
`else
   assign stall_int = 1'b0;
`endif

   always_comb begin
      alu_result = '0;
      alu_carry  = 1'b0;
      arith      = '0;
      shl_ext    = '0;
      shr_ext    = '0;
      case (bus.ALUOperation)
         OP_ADD, OP_ADC: begin
            arith = {1'b0, a_op} + {1'b0, b_op}
                  + {{W{1'b0}}, (bus.ALUOperation == OP_ADC) & c_reg};
            alu_result = arith[W-1:0];
            alu_carry  = arith[W];
         end
         // Bit W of the widened difference is set exactly when a borrow occurs.
         OP_SUB, OP_SBC: begin
            arith = {1'b0, a_op} - {1'b0, b_op}
                  - {{W{1'b0}}, (bus.ALUOperation == OP_SBC) & c_reg};
            alu_result = arith[W-1:0];
            alu_carry  = arith[W];
         end
         OP_AND: alu_result = a_op & b_op;
         OP_OR:  alu_result = a_op | b_op;
         OP_XOR: alu_result = a_op ^ b_op;
         OP_PSB: alu_result = b_op;
         OP_SHL: begin
            shl_ext    = {1'b0, a_op} << bus.shiftCount;
            alu_result = shl_ext[W-1:0];
            alu_carry  = shl_ext[W];
         end
         OP_SHR: begin
            shr_ext    = {a_op, 1'b0} >> bus.shiftCount;
            alu_result = shr_ext[W:1];
            alu_carry  = shr_ext[0];
         end
         OP_ROL: alu_result = (a_op << bus.shiftCount) | (a_op >> (W - int'(bus.shiftCount)));
         OP_ROR: alu_result = (a_op >> bus.shiftCount) | (a_op << (W - int'(bus.shiftCount)));
`ifdef EXEC_STAGE_MUL_EN
         OP_MUL: begin
            if (mul_done) begin
               alu_result = product_reg[W-1:0];
               alu_carry  = |product_reg[2*W-1:W];
            end
         end
`endif
         default: begin
            alu_result = '0;
            alu_carry  = 1'b0;
         end
      endcase
   end

   assign alu_out = stall_int ? '0 : alu_result;

   // Flags commit only on the cycle an instruction actually retires.
   always_ff @(posedge clk) begin
      if (rst) begin
         z_reg <= 1'b0;
         c_reg <= 1'b0;
      end else if (bus.opValid && !stall_int) begin
         if (bus.ZEn) begin
            z_reg <= (alu_out == '0);
         end
         if (bus.CEn) begin
            c_reg <= alu_carry;
         end
      end
   end

   assign bus.ALUOUT  = alu_out;
   assign bus.ZOutput = z_reg;
   assign bus.COutput = c_reg;
   assign bus.stall   = stall_int;
endmodule
